// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : PC sequencer fetching words over req/ack, holding them for decode
// Revision   : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_en,
    input  logic [15:0] jump_addr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic [15:0] instr_q;
    logic [15:0] instr_next;
    logic [15:0] instr_pc_q;
    logic [15:0] instr_pc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_ADDR;
            instr_q    <= 16'h0000;
            instr_pc_q <= 16'h0000;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            instr_q    <= instr_next;
            instr_pc_q <= instr_pc_next;
        end
    end

    // A jump overrides both the memory ack and the downstream handshake.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        instr_next    = instr_q;
        instr_pc_next = instr_pc_q;
        if (jump_en) begin
            pc_next    = jump_addr;
            state_next = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        instr_next    = mem_data;
                        instr_pc_next = pc;
                        pc_next       = pc + 16'h0001;
                        state_next    = HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        state_next = FETCH;
                    end
                end
                default: state_next = FETCH;
            endcase
        end
    end

    assign mem_req     = (state == FETCH);
    assign instr_valid = (state == HOLD);
    assign mem_addr    = pc;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed + randomized checks of fetch_unit against a model
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        instr_ready;

    logic        mem_req0, mem_req1;
    logic [15:0] mem_addr0, mem_addr1;
    logic [15:0] instr0, instr1;
    logic [15:0] instr_pc0, instr_pc1;
    logic        instr_valid0, instr_valid1;

    int checks = 0;
    int errors = 0;

    // Reference model of dut0 (RESET_ADDR = 0)
    logic [15:0] m_pc;
    logic        m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;

    fetch_unit dut0 (
        .clk(clk), .rst_n(rst_n), .jump_en(jump_en), .jump_addr(jump_addr),
        .mem_req(mem_req0), .mem_addr(mem_addr0), .mem_ack(mem_ack),
        .mem_data(mem_data), .instr(instr0), .instr_pc(instr_pc0),
        .instr_valid(instr_valid0), .instr_ready(instr_ready)
    );

    fetch_unit #(.RESET_ADDR(16'h0100)) dut1 (
        .clk(clk), .rst_n(rst_n), .jump_en(jump_en), .jump_addr(jump_addr),
        .mem_req(mem_req1), .mem_addr(mem_addr1), .mem_ack(mem_ack),
        .mem_data(mem_data), .instr(instr1), .instr_pc(instr_pc1),
        .instr_valid(instr_valid1), .instr_ready(instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc    = 16'h0000;
        m_valid = 1'b0;
        m_instr = 16'h0000;
        m_ipc   = 16'h0000;
    endtask

    // One clock: drive inputs, advance past the edge, update the model.
    // Memory data is derived from the model's own PC, never from the DUT.
    task automatic cycle(input logic ack, input logic ready, input logic jmp,
                         input logic [15:0] ja);
        logic [15:0] d;
        d           = ack ? (m_pc ^ 16'hA5A5) : 16'($urandom);
        mem_ack     = ack;
        mem_data    = d;
        instr_ready = ready;
        jump_en     = jmp;
        jump_addr   = ja;
        @(posedge clk);
        if (jmp) begin
            m_pc    = ja;
            m_valid = 1'b0;
        end else if (!m_valid) begin
            if (ack) begin
                m_instr = d;
                m_ipc   = m_pc;
                m_pc    = m_pc + 16'h0001;
                m_valid = 1'b1;
            end
        end else if (ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (mem_req0 !== 1'b1) begin errors++; $display("FAIL reset_mem_req got %b exp 1", mem_req0); end
        if (mem_addr0 !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr got %h exp 0000", mem_addr0); end
        if (instr0 !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h exp 0000", instr0); end
        if (instr_pc0 !== 16'h0000) begin errors++; $display("FAIL reset_instr_pc got %h exp 0000", instr_pc0); end
        if (instr_valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid0); end
        if (mem_addr1 !== 16'h0100) begin errors++; $display("FAIL reset_addr_param got %h exp 0100", mem_addr1); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_free_run();
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 1'b1, 1'b0, 16'h0000);
            checks++;
            if (instr_valid0 !== ((k % 2) == 0)) begin
                errors++; $display("FAIL free_valid k=%0d got %b exp %b", k, instr_valid0, (k % 2) == 0);
            end
            if ((k % 2) == 0) begin
                checks += 2;
                if (instr_pc0 !== 16'(k / 2)) begin
                    errors++; $display("FAIL free_instr_pc got %h exp %h", instr_pc0, 16'(k / 2));
                end
                if (instr0 !== (16'(k / 2) ^ 16'hA5A5)) begin
                    errors++; $display("FAIL free_instr got %h exp %h", instr0, 16'(k / 2) ^ 16'hA5A5);
                end
            end else begin
                checks++;
                if (mem_addr0 !== 16'(k / 2 + 1)) begin
                    errors++; $display("FAIL free_mem_addr got %h exp %h", mem_addr0, 16'(k / 2 + 1));
                end
            end
        end
    endtask

    task automatic test_wait_states();
        logic [15:0] a;
        int          high;
        if (m_valid) cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        for (int f = 0; f < 2; f++) begin
            a    = m_pc;
            high = 0;
            for (int w = 0; w < 4; w++) begin
                checks++;
                if (mem_req0 === 1'b1 && mem_addr0 === a) high++;
                else begin
                    errors++; $display("FAIL wait_req_addr w=%0d got req=%b addr=%h exp 1 %h", w, mem_req0, mem_addr0, a);
                end
                cycle(w == 3, 1'b1, 1'b0, 16'h0000);
            end
            checks += 3;
            if (high != 4) begin errors++; $display("FAIL wait_req_cycles got %0d exp 4", high); end
            if (instr_valid0 !== 1'b1) begin errors++; $display("FAIL wait_valid got %b exp 1", instr_valid0); end
            if (instr_pc0 !== a) begin errors++; $display("FAIL wait_instr_pc got %h exp %h", instr_pc0, a); end
            cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] hi, hp;
        if (m_valid) cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        hi = m_instr;
        hp = m_ipc;
        for (int c = 0; c < 5; c++) begin
            cycle(1'($urandom), 1'b0, 1'b0, 16'h0000);
            checks += 4;
            if (instr0 !== hi) begin errors++; $display("FAIL bp_instr got %h exp %h", instr0, hi); end
            if (instr_pc0 !== hp) begin errors++; $display("FAIL bp_instr_pc got %h exp %h", instr_pc0, hp); end
            if (mem_req0 !== 1'b0) begin errors++; $display("FAIL bp_mem_req got %b exp 0", mem_req0); end
            if (instr_valid0 !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", instr_valid0); end
        end
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        checks += 2;
        if (mem_req0 !== 1'b1) begin errors++; $display("FAIL bp_release_req got %b exp 1", mem_req0); end
        if (mem_addr0 !== hp + 16'h0001) begin errors++; $display("FAIL bp_next_addr got %h exp %h", mem_addr0, hp + 16'h0001); end
    endtask

    task automatic test_jump();
        logic [15:0] hi, hp;
        if (m_valid) cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 16'h0020);
        checks += 3;
        if (instr_valid0 !== 1'b0) begin errors++; $display("FAIL jmp_hold_valid got %b exp 0", instr_valid0); end
        if (mem_req0 !== 1'b1) begin errors++; $display("FAIL jmp_hold_req got %b exp 1", mem_req0); end
        if (mem_addr0 !== 16'h0020) begin errors++; $display("FAIL jmp_hold_addr got %h exp 0020", mem_addr0); end
        cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        checks += 2;
        if (instr_pc0 !== 16'h0020) begin errors++; $display("FAIL jmp_fetch_pc got %h exp 0020", instr_pc0); end
        if (instr0 !== (16'h0020 ^ 16'hA5A5)) begin errors++; $display("FAIL jmp_fetch_instr got %h exp %h", instr0, 16'h0020 ^ 16'hA5A5); end
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        hi = m_instr;
        hp = m_ipc;
        cycle(1'b1, 1'b1, 1'b1, 16'h0002);
        checks += 4;
        if (instr_valid0 !== 1'b0) begin errors++; $display("FAIL jmp_ack_valid got %b exp 0", instr_valid0); end
        if (instr0 !== hi) begin errors++; $display("FAIL jmp_ack_instr got %h exp %h", instr0, hi); end
        if (instr_pc0 !== hp) begin errors++; $display("FAIL jmp_ack_instr_pc got %h exp %h", instr_pc0, hp); end
        if (mem_addr0 !== 16'h0002) begin errors++; $display("FAIL jmp_ack_addr got %h exp 0002", mem_addr0); end
        cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (instr_pc0 !== 16'h0002) begin errors++; $display("FAIL jmp_ack_refetch got %h exp 0002", instr_pc0); end
    endtask

    task automatic test_wrap();
        if (m_valid) cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 16'hFFFF);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        checks += 2;
        if (instr_pc0 !== 16'hFFFF) begin errors++; $display("FAIL wrap_instr_pc got %h exp ffff", instr_pc0); end
        if (instr0 !== 16'h5A5A) begin errors++; $display("FAIL wrap_instr got %h exp 5a5a", instr0); end
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        checks++;
        if (mem_addr0 !== 16'h0000) begin errors++; $display("FAIL wrap_next_addr got %h exp 0000", mem_addr0); end
    endtask

    task automatic test_async_reset();
        if (m_valid) cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 16'h0007);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (instr_valid0 !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", instr_valid0); end
        if (instr0 !== 16'h0000) begin errors++; $display("FAIL arst_instr got %h exp 0000", instr0); end
        if (mem_addr0 !== 16'h0000) begin errors++; $display("FAIL arst_addr got %h exp 0000", mem_addr0); end
        if (mem_addr1 !== 16'h0100) begin errors++; $display("FAIL arst_addr_param got %h exp 0100", mem_addr1); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        checks += 4;
        if (instr_pc0 !== 16'h0000) begin errors++; $display("FAIL arst_resume_pc got %h exp 0000", instr_pc0); end
        if (instr0 !== 16'hA5A5) begin errors++; $display("FAIL arst_resume_instr got %h exp a5a5", instr0); end
        if (instr_pc1 !== 16'h0100) begin errors++; $display("FAIL arst_param_pc got %h exp 0100", instr_pc1); end
        if (instr_valid1 !== 1'b1) begin errors++; $display("FAIL arst_param_valid got %b exp 1", instr_valid1); end
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        checks++;
        if (mem_addr1 !== 16'h0101) begin errors++; $display("FAIL arst_param_next got %h exp 0101", mem_addr1); end
    endtask

    task automatic test_random();
        logic a, r, j;
        for (int n = 0; n < 400; n++) begin
            a = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 9) < 6);
            j = ($urandom_range(0, 9) == 0);
            cycle(a, r, j, 16'($urandom));
            checks += 5;
            if (mem_req0 !== !m_valid) begin errors++; $display("FAIL rnd_mem_req n=%0d got %b exp %b", n, mem_req0, !m_valid); end
            if (mem_addr0 !== m_pc) begin errors++; $display("FAIL rnd_mem_addr n=%0d got %h exp %h", n, mem_addr0, m_pc); end
            if (instr_valid0 !== m_valid) begin errors++; $display("FAIL rnd_valid n=%0d got %b exp %b", n, instr_valid0, m_valid); end
            if (instr0 !== m_instr) begin errors++; $display("FAIL rnd_instr n=%0d got %h exp %h", n, instr0, m_instr); end
            if (instr_pc0 !== m_ipc) begin errors++; $display("FAIL rnd_instr_pc n=%0d got %h exp %h", n, instr_pc0, m_ipc); end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        jump_en     = 1'b0;
        jump_addr   = 16'h0000;
        mem_ack     = 1'b0;
        mem_data    = 16'h0000;
        instr_ready = 1'b0;
        model_reset();
        test_reset();
        test_free_run();
        test_wait_states();
        test_backpressure();
        test_jump();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
